beep_pulse_gen: RTL and testbench

//   Output-side counterpart of the button conditioning path. Buttons turn levels into

---
 rtl/beep_pulse_gen_pkg.sv | 18 +
 rtl/beep_pulse_gen_cycle_timer.sv | 28 ++
 rtl/beep_pulse_gen.sv | 120 ++++++++++++
 tb/tb_beep_pulse_gen.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/beep_pulse_gen_pkg.sv
// Shared FSM encodings and default beep timing for the watch feedback blocks.
// The alarm and timer modes use the same ON/OFF defaults.
package beep_pulse_gen_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ON   = 2'd1;
    localparam logic [1:0] ST_OFF  = 2'd2;

    localparam int DEF_ON_CYCLES  = 50_000_000;
    localparam int DEF_OFF_CYCLES = 25_000_000;
    localparam int DEF_TMR_W      = 26;
    localparam int DEF_PEND_W     = 4;

    function automatic logic state_is_active(input logic [1:0] st);
        return (st == ST_ON) || (st == ST_OFF);
    endfunction

endpackage

// File: rtl/beep_pulse_gen_cycle_timer.sv
// Loadable down-counter that holds at zero; zero flags the last cycle of a phase.
module cycle_timer #(
    parameter int TMR_W = 26
) (
    input  logic             clk,
    input  logic             reset_p,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic             zero
);

    localparam logic [TMR_W-1:0] ONE = TMR_W'(1);

    logic [TMR_W-1:0] count_reg;

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - ONE;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/beep_pulse_gen.sv
// Turns a one-cycle trigger plus beep count into N timed ON/OFF bursts on out,
// with busy while running and a one-cycle done after the last beep.
module beep_pulse_gen
    import beep_pulse_gen_pkg::*;
#(
    parameter int ON_CYCLES  = DEF_ON_CYCLES,
    parameter int OFF_CYCLES = DEF_OFF_CYCLES,
    parameter int TMR_W      = DEF_TMR_W,
    parameter int PEND_W     = DEF_PEND_W,
    parameter int RETRIG     = 1
) (
    input  logic              clk,
    input  logic              reset_p,
    input  logic              trig,
    input  logic [PEND_W-1:0] beep_cnt,
    output logic              out,
    output logic              busy,
    output logic              done
);

    localparam logic [TMR_W-1:0]  ON_LOAD  = TMR_W'(ON_CYCLES - 1);
    localparam logic [TMR_W-1:0]  OFF_LOAD = TMR_W'(OFF_CYCLES - 1);
    localparam logic [PEND_W-1:0] ONE      = PEND_W'(1);

    logic [1:0]        state_reg, state_next;
    logic [PEND_W-1:0] remaining_reg, remaining_next;
    logic              out_reg, out_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;

    logic              timer_load;
    logic [TMR_W-1:0]  timer_load_val;
    logic              timer_zero;

    logic [PEND_W:0]   sum_wide;
    logic [PEND_W-1:0] sum_sat;
    logic              retrig_add;

    cycle_timer #(
        .TMR_W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .reset_p  (reset_p),
        .load     (timer_load),
        .load_val (timer_load_val),
        .zero     (timer_zero)
    );

    always_comb begin
        sum_wide       = {1'b0, remaining_reg} + {1'b0, beep_cnt};
        sum_sat        = sum_wide[PEND_W] ? '1 : sum_wide[PEND_W-1:0];
        retrig_add     = (RETRIG != 0) && trig && state_is_active(state_reg);
        remaining_next = retrig_add ? sum_sat : remaining_reg;
        state_next     = state_reg;
        timer_load     = 1'b0;
        timer_load_val = ON_LOAD;
        done_next      = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (trig && (beep_cnt != '0)) begin
                    state_next     = ST_ON;
                    remaining_next = beep_cnt;
                    timer_load     = 1'b1;
                    timer_load_val = ON_LOAD;
                end
            end
            ST_ON: begin
                // A same-cycle retrigger has already been folded in, so the
                // decrement applies to the saturated sum.
                if (timer_zero) begin
                    remaining_next = remaining_next - ONE;
                    if (remaining_next != '0) begin
                        state_next     = ST_OFF;
                        timer_load     = 1'b1;
                        timer_load_val = OFF_LOAD;
                    end else begin
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            ST_OFF: begin
                if (timer_zero) begin
                    state_next     = ST_ON;
                    timer_load     = 1'b1;
                    timer_load_val = ON_LOAD;
                end
            end
            default: begin
                state_next     = ST_IDLE;
                remaining_next = '0;
            end
        endcase

        out_next  = (state_next == ST_ON);
        busy_next = state_is_active(state_next);
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_reg     <= ST_IDLE;
            remaining_reg <= '0;
            out_reg       <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
            out_reg       <= out_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
        end
    end

    assign out  = out_reg;
    assign busy = busy_reg;
    assign done = done_reg;

endmodule

// File: tb/tb_beep_pulse_gen.sv
// Bench for beep_pulse_gen: a retriggering and a non-retriggering instance share
// stimulus; a timeline model predicts out/busy/done every cycle.
module tb_beep_pulse_gen;

    localparam int ON   = 4;
    localparam int OFF  = 3;
    localparam int PER  = ON + OFF;
    localparam int MAXR = 15;

    logic       clk = 1'b0;
    logic       reset_p = 1'b1;
    logic       trig = 1'b0;
    logic [3:0] beep_cnt = 4'd0;
    logic [1:0] out_w, busy_w, done_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Instance 0 accumulates retriggers, instance 1 ignores them.
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        beep_pulse_gen #(
            .ON_CYCLES  (ON),
            .OFF_CYCLES (OFF),
            .TMR_W      (3),
            .PEND_W     (4),
            .RETRIG     ((gi == 0) ? 1 : 0)
        ) u_dut (
            .clk      (clk),
            .reset_p  (reset_p),
            .trig     (trig),
            .beep_cnt (beep_cnt),
            .out      (out_w[gi]),
            .busy     (busy_w[gi]),
            .done     (done_w[gi])
        );
    end

    // Timeline model: a sequence of N beeps started at edge S has out high for
    // edges S+k with k%PER<ON, busy for k<N*PER-OFF and done at k==N*PER-OFF.
    int edge_no = 0;
    bit m_active [2];
    int m_start  [2];
    int m_n      [2];

    function automatic int seq_len(input int n);
        return n * PER - OFF;
    endfunction

    function automatic bit was_busy(input int i, input int e_prev);
        return m_active[i] && ((e_prev - m_start[i]) < seq_len(m_n[i]));
    endfunction

    function automatic int beeps_ended_before(input int k);
        int c = 0;
        while (c * PER + ON < k) c++;
        return c;
    endfunction

    function automatic int retrig_total(input int i, input int e, input int add);
        int d = beeps_ended_before(e - m_start[i]);
        int t = (m_n[i] - d) + add;
        if (t > MAXR) t = MAXR;
        return d + t;
    endfunction

    function automatic logic [2:0] expect_bits(input int i);
        int k;
        int l;
        if (!m_active[i]) return 3'b000;
        k = edge_no - m_start[i];
        l = seq_len(m_n[i]);
        return {(k < l) && ((k % PER) < ON), k < l, k == l};
    endfunction

    always @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            for (int i = 0; i < 2; i++) m_active[i] <= 1'b0;
        end else begin
            edge_no <= edge_no + 1;
            for (int i = 0; i < 2; i++) begin
                if (trig) begin
                    if (was_busy(i, edge_no)) begin
                        if (i == 0) m_n[i] <= retrig_total(i, edge_no + 1, int'(beep_cnt));
                    end else if (beep_cnt != 4'd0) begin
                        m_active[i] <= 1'b1;
                        m_start[i]  <= edge_no + 1;
                        m_n[i]      <= int'(beep_cnt);
                    end
                end
            end
        end
    end

    int cyc;
    int beeps    [2];
    int busy_cyc [2];
    int done_cnt [2];
    int done_at  [2];
    bit prev_out [2];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_stats();
        cyc = 0;
        for (int i = 0; i < 2; i++) begin
            beeps[i] = 0; busy_cyc[i] = 0; done_cnt[i] = 0; done_at[i] = 0;
            prev_out[i] = out_w[i];
        end
    endtask

    // One clock: sample at the falling edge, compare against the model, update stats.
    task automatic step();
        logic [2:0] e;
        @(negedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            e = expect_bits(i);
            check($sformatf("out%0d", i),  int'(out_w[i]),  int'(e[2]));
            check($sformatf("busy%0d", i), int'(busy_w[i]), int'(e[1]));
            check($sformatf("done%0d", i), int'(done_w[i]), int'(e[0]));
            if (out_w[i] && !prev_out[i]) beeps[i]++;
            prev_out[i] = out_w[i];
            if (busy_w[i]) busy_cyc[i]++;
            if (done_w[i]) begin
                done_cnt[i]++;
                if (done_at[i] == 0) done_at[i] = cyc;
            end
        end
    endtask

    task automatic run(input int n);
        for (int j = 0; j < n; j++) step();
    endtask

    task automatic pulse(input int cnt);
        trig = 1'b1;
        beep_cnt = 4'(cnt);
        step();
        trig = 1'b0;
        beep_cnt = 4'd0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy_w != 2'b00) && (n < 400)) begin
            step();
            n++;
        end
        if (busy_w != 2'b00) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout waiting for idle, busy=%b", name, busy_w);
        end
        run(2);
    endtask

    task automatic report(input string name, input int i, input int b, input int bc, input int dc);
        check({name, "_beeps"}, beeps[i], b);
        check({name, "_busy_cycles"}, busy_cyc[i], bc);
        check({name, "_dones"}, done_cnt[i], dc);
        $display("%s inst%0d: beeps=%0d busy_cycles=%0d dones=%0d done_at=%0d",
                 name, i, beeps[i], busy_cyc[i], done_cnt[i], done_at[i]);
    endtask

    initial begin
        clear_stats();
        run(3);
        @(negedge clk);
        reset_p = 1'b0;
        clear_stats();
        run(2);
        check("reset_idle", int'({out_w, busy_w, done_w}), 0);

        // Single beep: 4 cycles high, done in cycle 5.
        clear_stats();
        pulse(1);
        wait_idle("single");
        report("single", 0, 1, 4, 1);
        check("single_done_at", done_at[0], 5);

        // Three beeps: 18 busy cycles, done in cycle 19.
        clear_stats();
        pulse(3);
        wait_idle("triple");
        report("triple", 0, 3, 18, 1);
        check("triple_done_at", done_at[0], 19);

        // Zero count in idle does nothing.
        clear_stats();
        pulse(0);
        run(20);
        report("zero", 0, 0, 0, 0);
        report("zero", 1, 0, 0, 0);

        // Retrigger of 2 during the second beep.
        clear_stats();
        pulse(3);
        run(8);
        pulse(2);
        wait_idle("retrig");
        report("retrig", 0, 5, 32, 1);
        report("retrig", 1, 3, 18, 1);

        // 14 pending plus 5 saturates at 15 beeps.
        clear_stats();
        pulse(14);
        run(1);
        pulse(5);
        wait_idle("sat");
        report("sat", 0, 15, 102, 1);
        report("sat", 1, 14, 95, 1);

        // Trigger landing on the final ON cycle of the last beep.
        clear_stats();
        pulse(1);
        run(3);
        pulse(1);
        wait_idle("last_cycle");
        report("last_cycle", 0, 2, 11, 1);
        check("last_cycle_done_at0", done_at[0], 12);
        report("last_cycle", 1, 1, 4, 1);
        check("last_cycle_done_at1", done_at[1], 5);

        // Asynchronous reset in the middle of a beep, then a fresh sequence.
        clear_stats();
        pulse(3);
        run(2);
        #2 reset_p = 1'b1;
        #1 check("async_reset_out_busy", int'({out_w, busy_w}), 0);
        #1 reset_p = 1'b0;
        run(20);
        report("reset_mid", 0, 1, 3, 0);
        clear_stats();
        pulse(2);
        wait_idle("after_reset");
        report("after_reset", 0, 2, 11, 1);
        report("after_reset", 1, 2, 11, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
